// File: rtl/trig_node_pkg.sv
// Shared codes, state encoding and helpers for the multi-channel trigger node.
package trig_node_pkg;

    localparam logic [2:0] EDGE_LOW  = 3'b001;
    localparam logic [2:0] EDGE_HIGH = 3'b010;
    localparam logic [2:0] EDGE_RISE = 3'b011;
    localparam logic [2:0] EDGE_FALL = 3'b100;
    localparam logic [2:0] EDGE_ANY  = 3'b101;

    localparam logic [1:0] LOGIC_AND  = 2'd0;
    localparam logic [1:0] LOGIC_OR   = 2'd1;
    localparam logic [1:0] LOGIC_NAND = 2'd2;
    localparam logic [1:0] LOGIC_NOR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TRIGGERED,
        DONE
    } state_t;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/trigger_node_multi_if.sv
// Probe/config inputs and capture-RAM/status outputs of the trigger node.
interface trigger_node_multi_if #(
    parameter int DET_NUM = 4,
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 8
);
    logic                   arm;
    logic                   abort;
    logic                   pause;
    logic [DET_NUM-1:0]     trig_din;
    logic [1:0]             trig_logic;
    logic [DET_NUM*3-1:0]   trig_edge_mode;
    logic [CNT_W-1:0]       trig_cnt;
    logic [ADDR_W-1:0]      trig_len;

    logic                   wt_ce;
    logic                   wt_en;
    logic [ADDR_W-1:0]      wt_addr;
    logic                   trig_hit;
    logic [ADDR_W-1:0]      trig_addr;
    logic                   stop_flag;
    logic [ADDR_W-1:0]      stop_addr;
    logic                   overflow_flag;
    logic                   busy;

    modport master (
        output arm, abort, pause, trig_din, trig_logic, trig_edge_mode, trig_cnt, trig_len,
        input  wt_ce, wt_en, wt_addr, trig_hit, trig_addr, stop_flag, stop_addr,
               overflow_flag, busy
    );

    modport slave (
        input  arm, abort, pause, trig_din, trig_logic, trig_edge_mode, trig_cnt, trig_len,
        output wt_ce, wt_en, wt_addr, trig_hit, trig_addr, stop_flag, stop_addr,
               overflow_flag, busy
    );
endinterface

// File: rtl/trig_det_chan.sv
// One probe channel: level/edge match of the current sample against its code.
module trig_det_chan
    import trig_node_pkg::*;
(
    input  logic       din,
    input  logic       din_d1,
    input  logic       vld_p1,
    input  logic [2:0] mode,
    output logic       match,
    output logic       care
);

    // Edge codes need a valid previous sample; level codes never do.
    always_comb begin
        match = 1'b0;
        care  = 1'b1;
        case (mode)
            EDGE_LOW:  match = ~din;
            EDGE_HIGH: match = din;
            EDGE_RISE: match = vld_p1 & ~din_d1 & din;
            EDGE_FALL: match = vld_p1 & din_d1 & ~din;
            EDGE_ANY:  match = vld_p1 & (din_d1 ^ din);
            default:   care  = 1'b0;
        endcase
    end

endmodule

// File: rtl/trigger_node_multi.sv
// Multi-channel trigger node: combines channel matches, counts occurrences and
// drives the capture RAM as a ring buffer with programmable post-trigger length.
module trigger_node_multi
    import trig_node_pkg::*;
#(
    parameter int DET_NUM = 4,
    parameter int DEPTH   = 5461,
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 8
) (
    input logic                 trig_clk,
    input logic                 trig_rst,
    trigger_node_multi_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   wt_addr, trig_addr_q, stop_addr_q, post, post_load;
    logic [CNT_W-1:0]    occ;
    logic [DET_NUM-1:0]  din_d1;
    logic                vld_p1;
    logic                stop_q, ovf_q;

    logic [DET_NUM-1:0]  match_p0, care_p0;
    logic                hit_p0, busy_c, wr, fire, last, ctl_ovr;
    logic                any_care, all_hit, any_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    for (genvar i = 0; i < DET_NUM; i++) begin : g_chan
        trig_det_chan u_chan (
            .din    (bus.trig_din[i]),
            .din_d1 (din_d1[i]),
            .vld_p1 (vld_p1),
            .mode   (bus.trig_edge_mode[3*i +: 3]),
            .match  (match_p0[i]),
            .care   (care_p0[i])
        );
    end

    // Stage p0: combine over cared channels; with no cared channel nothing matches.
    always_comb begin
        any_care = |care_p0;
        all_hit  = &(match_p0 | ~care_p0);
        any_hit  = |(match_p0 & care_p0);
        hit_p0   = 1'b0;
        case (bus.trig_logic)
            LOGIC_AND:  hit_p0 = any_care & all_hit;
            LOGIC_OR:   hit_p0 = any_hit;
            LOGIC_NAND: hit_p0 = any_care & ~all_hit;
            LOGIC_NOR:  hit_p0 = any_care & ~any_hit;
            default:    hit_p0 = 1'b0;
        endcase
    end

    assign post_load = ADDR_W'(clamp_len(32'(bus.trig_len), DEPTH - 1));
    assign ctl_ovr   = bus.arm | bus.abort;
    assign wr        = busy_c & ~bus.pause;

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        fire      = 1'b0;
        last      = 1'b0;
        case (state)
            ARMED: begin
                busy_c = 1'b1;
                fire   = ~bus.pause & hit_p0 & (occ == bus.trig_cnt) & ~ctl_ovr;
                if (fire) state_nxt = (post_load == '0) ? DONE : TRIGGERED;
            end
            TRIGGERED: begin
                busy_c = 1'b1;
                last   = ~bus.pause & (post == ADDR_W'(1)) & ~ctl_ovr;
                if (last) state_nxt = DONE;
            end
            default: ;
        endcase
        if (bus.abort)    state_nxt = IDLE;
        else if (bus.arm) state_nxt = ARMED;
    end

    // Stage p1: state, ring address, occurrence/post counters and sample history.
    always_ff @(posedge trig_clk or posedge trig_rst) begin
        if (trig_rst) begin
            state       <= IDLE;
            wt_addr     <= '0;
            occ         <= '0;
            post        <= '0;
            din_d1      <= '0;
            vld_p1      <= 1'b0;
            trig_addr_q <= '0;
            stop_addr_q <= '0;
            stop_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!bus.abort) begin
                if (bus.arm) begin
                    wt_addr     <= '0;
                    occ         <= '0;
                    post        <= '0;
                    vld_p1      <= 1'b0;
                    trig_addr_q <= '0;
                    stop_addr_q <= '0;
                    stop_q      <= 1'b0;
                    ovf_q       <= 1'b0;
                end else if (wr) begin
                    din_d1  <= bus.trig_din;
                    vld_p1  <= 1'b1;
                    wt_addr <= (wt_addr == LAST_ADDR) ? '0 : wt_addr + 1'b1;
                    if (wt_addr == LAST_ADDR) ovf_q <= 1'b1;
                    if (state == ARMED && hit_p0) occ <= sat_inc(occ);
                    if (fire) begin
                        trig_addr_q <= wt_addr;
                        post        <= post_load;
                        if (post_load == '0) begin
                            stop_addr_q <= wt_addr;
                            stop_q      <= 1'b1;
                        end
                    end
                    if (state == TRIGGERED) begin
                        if (last) begin
                            stop_addr_q <= wt_addr;
                            stop_q      <= 1'b1;
                        end else begin
                            post <= post - 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.wt_ce         = busy_c;
    assign bus.busy          = busy_c;
    assign bus.wt_en         = wr;
    assign bus.trig_hit      = fire;
    assign bus.wt_addr       = wt_addr;
    assign bus.trig_addr     = trig_addr_q;
    assign bus.stop_addr     = stop_addr_q;
    assign bus.stop_flag     = stop_q;
    assign bus.overflow_flag = ovf_q;

endmodule
